// File: rtl/bram_fault_injector.sv
// bram_fault_injector: owns the data BRAM port and flips or sets one bit of one word.
// Optional post-write verify read is enabled by defining FI_READBACK_EN.
module bram_fault_injector #(
    parameter int          ADDR_WIDTH   = 12,
    parameter logic [31:0] MEM_BASE     = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memory_fault_enable,
    input  logic [31:0]           memory_target_addr,
    input  logic [4:0]            memory_target_bit,
    input  logic                  memory_fault_type,
    output logic                  inj_req,
    input  logic                  inj_gnt,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]           bram_wdata,
    input  logic [31:0]           bram_rdata,
    output logic                  inj_busy,
    output logic                  inj_done,
    output logic                  inj_error,
    output logic [31:0]           old_word,
    output logic [31:0]           new_word,
    output logic [7:0]            drop_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_ERR, S_REQ, S_READ, S_WAIT,
        S_WRITE, S_VREAD, S_VWAIT, S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [4:0]            bit_q, bit_d;
    logic                  type_q, type_d;
    logic [1:0]            wcnt_q, wcnt_d;
    logic [31:0]           old_q, old_d;
    logic [31:0]           new_q, new_d;
    logic [7:0]            drop_q, drop_d;
`ifdef FI_READBACK_EN
    logic                  vfail_q, vfail_d;
`endif

    // Word offset from the BRAM base; byte-lane bits are ignored.
    logic [29:0] off_w;
    logic        below_w, over_w, wait_last_w;
    logic [31:0] mask_w;
    logic        unused_lsb;

    assign unused_lsb  = ^memory_target_addr[1:0];
    assign off_w       = memory_target_addr[31:2] - MEM_BASE[31:2];
    assign below_w     = memory_target_addr[31:2] < MEM_BASE[31:2];
    assign over_w      = |off_w[29:ADDR_WIDTH];
    assign wait_last_w = (wcnt_q == 2'(READ_LATENCY - 1));
    assign mask_w      = 32'h1 << bit_q;

    assign old_word   = old_q;
    assign new_word   = new_q;
    assign drop_count = drop_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            type_q  <= 1'b0;
            wcnt_q  <= '0;
            old_q   <= '0;
            new_q   <= '0;
            drop_q  <= '0;
`ifdef FI_READBACK_EN
            vfail_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            type_q  <= type_d;
            wcnt_q  <= wcnt_d;
            old_q   <= old_d;
            new_q   <= new_d;
            drop_q  <= drop_d;
`ifdef FI_READBACK_EN
            vfail_q <= vfail_d;
`endif
        end
    end

    // Next-state logic and Moore outputs of the read-modify-write sequence.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bit_d      = bit_q;
        type_d     = type_q;
        wcnt_d     = wcnt_q;
        old_d      = old_q;
        new_d      = new_q;
        drop_d     = drop_q;
`ifdef FI_READBACK_EN
        vfail_d    = vfail_q;
`endif
        inj_req    = 1'b0;
        bram_en    = 1'b0;
        bram_we    = 4'h0;
        bram_addr  = '0;
        bram_wdata = '0;
        inj_busy   = (state_q != S_IDLE);
        inj_done   = 1'b0;
        inj_error  = 1'b0;

        if (inj_busy && memory_fault_enable && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (memory_fault_enable) begin
                    idx_d   = off_w[ADDR_WIDTH-1:0];
                    bit_d   = memory_target_bit;
                    type_d  = memory_fault_type;
                    state_d = (below_w || over_w) ? S_ERR : S_REQ;
                end
            end
            S_ERR: begin
                inj_error = 1'b1;
                state_d   = S_IDLE;
            end
            S_REQ: begin
                inj_req = 1'b1;
                if (inj_gnt) state_d = S_READ;
            end
            S_READ: begin
                inj_req   = 1'b1;
                bram_en   = 1'b1;
                bram_addr = idx_q;
                wcnt_d    = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                inj_req = 1'b1;
                wcnt_d  = wcnt_q + 2'd1;
                if (wait_last_w) begin
                    old_d   = bram_rdata;
                    new_d   = type_q ? (bram_rdata | mask_w)
                                     : (bram_rdata ^ mask_w);
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                inj_req    = 1'b1;
                bram_en    = 1'b1;
                bram_we    = 4'hF;
                bram_addr  = idx_q;
                bram_wdata = new_q;
`ifdef FI_READBACK_EN
                state_d    = S_VREAD;
`else
                state_d    = S_DONE;
`endif
            end
`ifdef FI_READBACK_EN
            S_VREAD: begin
                inj_req   = 1'b1;
                bram_en   = 1'b1;
                bram_addr = idx_q;
                wcnt_d    = '0;
                state_d   = S_VWAIT;
            end
            S_VWAIT: begin
                inj_req = 1'b1;
                wcnt_d  = wcnt_q + 2'd1;
                if (wait_last_w) begin
                    vfail_d = (bram_rdata != new_q);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                inj_done = 1'b1;
`ifdef FI_READBACK_EN
                inj_error = vfail_q;
`endif
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bram_fault_injector.sv
// Randomized bench for bram_fault_injector with a transaction-timeline model.
// Define FI_READBACK_EN to also exercise the verify read.
module tb_bram_fault_injector;

    localparam int AW    = 12;
    localparam int RL    = 1;
    localparam int DEPTH = 1 << AW;
    localparam int R_WR  = 2 + RL;
`ifdef FI_READBACK_EN
    localparam int R_DONE = 4 + 2 * RL;
`else
    localparam int R_DONE = 3 + RL;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          en = 1'b0;
    logic [31:0]   taddr = '0;
    logic [4:0]    tbit = '0;
    logic          ttyp = 1'b0;
    logic          gnt = 1'b0;
    logic          inj_req, bram_en, inj_busy, inj_done, inj_error;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wdata, bram_rdata, old_word, new_word;
    logic [7:0]    drop_count;

    logic          en2 = 1'b0;
    logic [31:0]   addr2 = '0;
    logic          gnt2 = 1'b1;
    logic [31:0]   rdata2 = '0;
    logic          req2, ben2, busy2, done2, err2;
    logic [3:0]    we2;
    logic [AW-1:0] baddr2;
    logic [31:0]   wdata2, old2, new2;
    logic [7:0]    drop2;

    int tests = 0;
    int fails = 0;

    bram_fault_injector #(.ADDR_WIDTH(AW), .MEM_BASE(32'h0), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst),
        .memory_fault_enable(en), .memory_target_addr(taddr),
        .memory_target_bit(tbit), .memory_fault_type(ttyp),
        .inj_req(inj_req), .inj_gnt(gnt),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .inj_busy(inj_busy), .inj_done(inj_done), .inj_error(inj_error),
        .old_word(old_word), .new_word(new_word), .drop_count(drop_count)
    );

    bram_fault_injector #(.ADDR_WIDTH(AW), .MEM_BASE(32'h100), .READ_LATENCY(RL)) dut2 (
        .clk(clk), .rst(rst),
        .memory_fault_enable(en2), .memory_target_addr(addr2),
        .memory_target_bit(5'd0), .memory_fault_type(1'b0),
        .inj_req(req2), .inj_gnt(gnt2),
        .bram_en(ben2), .bram_we(we2), .bram_addr(baddr2),
        .bram_wdata(wdata2), .bram_rdata(rdata2),
        .inj_busy(busy2), .inj_done(done2), .inj_error(err2),
        .old_word(old2), .new_word(new2), .drop_count(drop2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // BRAM behavioural model with selectable read latency
    logic [31:0] mem [DEPTH];
    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;
    logic        wrote = 1'b0;
    logic        corrupt = 1'b0;
    int          wcount = 0;
    always @(posedge clk) begin
        rd2 <= rd1;
        if (bram_en) begin
            if (bram_we == 4'hF) begin
                mem[bram_addr] <= bram_wdata;
                wrote <= 1'b1;
                wcount <= wcount + 1;
            end else begin
                rd1 <= mem[bram_addr] ^ ((corrupt && wrote) ? 32'h1 : 32'h0);
                wrote <= 1'b0;
            end
        end
    end
    assign bram_rdata = (RL == 1) ? rd1 : rd2;

    // Arbiter: grants after gnt_delay cycles of request, holds until release
    int gnt_delay = 0;
    int gwait = 0;
    always @(posedge clk) begin
        #1;
        if (!inj_req) begin
            gnt = 1'b0;
            gwait = 0;
        end else if (!gnt) begin
            if (gwait >= gnt_delay) gnt = 1'b1;
            else gwait++;
        end
    end

    // Transaction model: k counts cycles since acceptance, g is the grant cycle
    logic [31:0] m_mem [DEPTH];
    bit          m_act = 0, m_bad = 0, m_vf = 0;
    int          m_k = 0, m_g = 0, m_drop = 0;
    int          m_idx = 0;
    logic [31:0] m_oldp = '0, m_newp = '0, m_old = '0, m_new = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 0; m_k = 0; m_g = 0; m_drop = 0;
            m_old = '0; m_new = '0;
        end else if (m_act) begin
            if (en) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            if (!m_bad && m_g == 0 && gnt) m_g = m_k;
            if (!m_bad && m_g != 0 && m_k - m_g == R_WR - 1) begin
                m_old = m_oldp;
                m_new = m_newp;
            end
            if (!m_bad && m_g != 0 && m_k - m_g == R_WR) m_mem[m_idx] = m_newp;
            if ((m_bad && m_k == 1) || (!m_bad && m_g != 0 && m_k - m_g == R_DONE))
                m_act = 0;
            else
                m_k++;
        end else if (en) begin
            longint a;
            a = longint'({taddr[31:2], 2'b00});
            m_bad = (a >> 2) >= DEPTH;
            m_idx = int'(a >> 2) % DEPTH;
            m_oldp = m_mem[m_idx];
            m_newp = ttyp ? (m_oldp | (32'h1 << tbit)) : (m_oldp ^ (32'h1 << tbit));
            m_vf = corrupt;
            m_act = 1; m_k = 1; m_g = 0;
        end
    end

    // Per-cycle comparison of every output against the model
    logic check_on = 1'b0;
    always @(negedge clk) begin
        if (check_on && !rst) begin
            int r;
            bit hit, e_wr, e_en, e_err;
            r = m_k - m_g;
            hit = m_act && !m_bad && m_g != 0;
            e_wr = hit && r == R_WR;
            e_en = hit && (r == 1 || r == R_WR);
`ifdef FI_READBACK_EN
            e_en = e_en || (hit && r == R_WR + 1);
            e_err = (m_act && m_bad) || (hit && r == R_DONE && m_vf);
`else
            e_err = m_act && m_bad;
`endif
            chk("busy", {31'b0, inj_busy}, {31'b0, m_act});
            chk("req", {31'b0, inj_req}, {31'b0, m_act && !m_bad && (m_g == 0 || r < R_DONE)});
            chk("done", {31'b0, inj_done}, {31'b0, hit && r == R_DONE});
            chk("error", {31'b0, inj_error}, {31'b0, e_err});
            chk("bram_en", {31'b0, bram_en}, {31'b0, e_en});
            chk("bram_we", {28'b0, bram_we}, e_wr ? 32'hF : 32'h0);
            if (e_en) chk("bram_addr", {20'b0, bram_addr}, m_idx);
            if (e_wr) chk("bram_wdata", bram_wdata, m_newp);
            chk("old_word", old_word, m_old);
            chk("new_word", new_word, m_new);
            chk("drop_count", {24'b0, drop_count}, m_drop);
        end
    end

    task automatic cmd(input logic [31:0] a, input logic [4:0] b, input logic t);
        @(posedge clk); #1;
        taddr = a; tbit = b; ttyp = t; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic cmd2(input logic [31:0] a);
        @(posedge clk); #1;
        addr2 = a; en2 = 1'b1;
        @(posedge clk); #1;
        en2 = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((inj_busy || busy2) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {30'b0, inj_busy, busy2}, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, w0, bad;
        logic [31:0] s0, s1;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            m_mem[i] = mem[i];
        end
        mem[5] = 32'h0000_00F0;
        m_mem[5] = 32'h0000_00F0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, inj_req}, 0);
        chk("rst_en", {31'b0, bram_en}, 0);
        chk("rst_we", {28'b0, bram_we}, 0);
        chk("rst_busy", {31'b0, inj_busy}, 0);
        chk("rst_old", old_word, 0);
        chk("rst_drop", {24'b0, drop_count}, 0);
        rst = 1'b0;
        check_on = 1'b1;

        // Bit flip on word 5 with immediate grant
        cmd(32'h14, 5'd4, 1'b0);
        c = 1;
        while (c <= 20) begin
            @(negedge clk);
            if (inj_done) break;
            c++;
        end
        chk("done_cycle", c, 5);
        wait_idle();
        chk("flip_old", old_word, 32'h0000_00F0);
        chk("flip_new", new_word, 32'h0000_00E0);
        chk("flip_mem", mem[5], 32'h0000_00E0);

        // Stuck-at-1 on bit 31, then repeated on an already-set bit
        mem[5] = 32'h0000_00F0;
        m_mem[5] = 32'h0000_00F0;
        cmd(32'h14, 5'd31, 1'b1);
        wait_idle();
        chk("sa1_new", new_word, 32'h8000_00F0);
        w0 = wcount;
        cmd(32'h17, 5'd31, 1'b1);
        wait_idle();
        chk("sa1_rep_old", old_word, 32'h8000_00F0);
        chk("sa1_rep_new", new_word, 32'h8000_00F0);
        chk("sa1_rep_write", wcount - w0, 1);

        // Grant stalled for 10 cycles
        gnt_delay = 10;
        cmd(32'h20, 5'd0, 1'b0);
        c = 1;
        while (c <= 40) begin
            @(negedge clk);
            if (bram_en) break;
            c++;
        end
        chk("stall_read_cycle", c, 12);
        wait_idle();
        gnt_delay = 0;

        // Out-of-range addresses
        w0 = wcount;
        cmd(32'h4000, 5'd0, 1'b0);
        @(negedge clk);
        chk("oor_err", {31'b0, inj_error}, 1);
        chk("oor_req", {31'b0, inj_req}, 0);
        @(negedge clk);
        chk("oor_err_off", {31'b0, inj_error}, 0);
        wait_idle();
        chk("oor_nowrite", wcount - w0, 0);
        cmd2(32'h80);
        @(negedge clk);
        chk("below_err", {31'b0, err2}, 1);
        chk("below_req", {30'b0, req2, ben2}, 0);
        wait_idle();
        cmd2(32'h4100);
        @(negedge clk);
        chk("base_over_err", {31'b0, err2}, 1);
        wait_idle();
        cmd2(32'h114);
        @(negedge clk);
        chk("base_ok_req", {30'b0, req2, err2}, 32'h2);
        wait_idle();

        // Three drops during one busy operation
        do_reset();
        s1 = mem[13];
        gnt_delay = 5;
        cmd(32'h30, 5'd1, 1'b0);
        taddr = 32'h34;
        repeat (3) begin
            @(posedge clk); #1; en = 1'b1;
            @(posedge clk); #1; en = 1'b0;
        end
        wait_idle();
        chk("drop3", {24'b0, drop_count}, 3);
        chk("drop3_other_word", mem[13], s1);

        // Saturation after 260 drops
        gnt_delay = 300;
        cmd(32'h40, 5'd2, 1'b0);
        en = 1'b1;
        repeat (260) @(posedge clk);
        #1;
        en = 1'b0;
        chk("drop_sat", {24'b0, drop_count}, 32'hFF);
        wait_idle();
        gnt_delay = 0;

        // Reset in the WAIT cycle
        do_reset();
        s0 = mem[20];
        cmd(32'h50, 5'd3, 1'b0);
        w0 = wcount;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, inj_req}, 0);
        chk("mid_rst_en", {31'b0, bram_en}, 0);
        chk("mid_rst_busy", {31'b0, inj_busy}, 0);
        chk("mid_rst_old", old_word, 0);
        chk("mid_rst_new", new_word, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_nowrite", wcount - w0, 0);
        chk("mid_rst_mem", mem[20], s0);

`ifdef FI_READBACK_EN
        // Corrupted verify read
        corrupt = 1'b1;
        cmd(32'h60, 5'd0, 1'b0);
        c = 1;
        while (c <= 30) begin
            @(negedge clk);
            if (inj_done) break;
            c++;
        end
        chk("verify_err", {30'b0, inj_done, inj_error}, 32'h3);
        wait_idle();
        corrupt = 1'b0;
`endif

        // Randomized commands, grants and drops
        do_reset();
        repeat (900) begin
            @(posedge clk); #1;
            en = ($urandom_range(0, 3) == 0);
            tbit = 5'($urandom);
            ttyp = 1'($urandom);
            case ($urandom_range(0, 7))
                0: taddr = 32'h4000 + $urandom_range(0, 65535);
                1: taddr = 32'h3FFC | 32'($urandom_range(0, 3));
                default: taddr = 32'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 15) == 0) gnt_delay = $urandom_range(0, 3);
        end
        en = 1'b0;
        wait_idle();

        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== m_mem[i]) bad++;
        chk("mem_final", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
